aes_inv_cipher_core: RTL and testbench

Iterative AES-128 decryption datapath: accepts one 128-bit ciphertext block, applies the 10-round inverse cipher one round per clock, and returns the plaintext. It uses the same byte/column state mapping as the encryption path and is its counterpart on the decrypt side. Round keys come from an external key-schedule store, indexed combinationally by the core. Inverse S-box lookup uses the team's combinational `inv_sbox` byte module, instantiated 16 times.

---
 rtl/aes_inv_cipher_core.sv | 158 +++++++++++++++
 tb/tb_aes_inv_cipher_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched
// combinationally from an external key-schedule store via rk_idx.

module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    endfunction

    assign out_byte = gf_inv(inv_affine(in_byte));
endmodule

module aes_inv_cipher_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    output logic [127:0] pt_out
);
    typedef enum logic [1:0] {IDLE, RUN, FINAL} state_e;

    state_e       state_q, state_d;
    logic [127:0] s_q, s_d;
    logic [3:0]   r_q, r_d;
    logic [127:0] pt_q, pt_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] sub_bytes;
    logic [127:0] add_round;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0]    o;
        logic [3:0][7:0] a;
        logic [3:0][7:0] x2, x4, x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a = s[32*c +: 32];
            for (int r = 0; r < 4; r++) begin
                x2[r] = xt(a[r]);
                x4[r] = xt(x2[r]);
                x8[r] = xt(x4[r]);
            end
            // 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3, rotated per output row.
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                                  ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                                  ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                                  ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
            end
        end
        return o;
    endfunction

    // InvShiftRows is pure wiring: output byte i reads the rotated source byte.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        localparam int ROW = i % 4;
        localparam int COL = i / 4;
        localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
        inv_sbox u_inv_sbox (
            .in_byte  (s_q[8*SRC +: 8]),
            .out_byte (sub_bytes[8*i +: 8])
        );
    end

    assign add_round = sub_bytes ^ rk;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path through the case can infer a latch.
        state_d     = state_q;
        s_d         = s_q;
        r_d         = r_q;
        pt_d        = pt_q;
        out_valid_d = 1'b0;
        in_ready    = 1'b0;
        rk_idx      = 4'd0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                rk_idx   = 4'd10;
                if (in_valid) begin
                    s_d     = ct_in ^ rk;
                    r_d     = 4'd9;
                    state_d = RUN;
                end
            end
            RUN: begin
                rk_idx = r_q;
                s_d    = inv_mix_columns(add_round);
                if (r_q == 4'd1) state_d = FINAL;
                else             r_d     = r_q - 4'd1;
            end
            FINAL: begin
                pt_d        = add_round;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            r_q         <= '0;
            pt_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            r_q         <= r_d;
            pt_q        <= pt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pt_out    = pt_q;
endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Scoreboard bench for aes_inv_cipher_core: FIPS-197 vectors plus random blocks
// checked against a byte-level reference inverse cipher with its own key expansion.

module tb_aes_inv_cipher_core;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] ct_in = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic [127:0] pt_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int           stamp;
        logic [127:0] pt;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0]   sbox_t[256];
    logic [7:0]   inv_t[256];
    logic [127:0] rks[16][11];
    int           pres_slot = 0;
    int           cur_slot = 0;
    logic [127:0] pres_exp = '0;
    logic [127:0] last_pt = '0;

    aes_inv_cipher_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct_in     (ct_in),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .pt_out    (pt_out)
    );

    always #5 clk = ~clk;

    // Key store: the accept cycle (index 10) serves the block being offered.
    assign rk = (rk_idx == 4'd10) ? rks[pres_slot][10]
              : (rk_idx < 4'd10)  ? rks[cur_slot][rk_idx] : '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= p;
            p = (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] bswap(input logic [127:0] v);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = v[8*(15-i) +: 8];
        return o;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_t[sbox_t[x]] = 8'(x);
    endtask

    task automatic expand_key(input logic [127:0] key, input int slot);
        logic [7:0] kb[176];
        logic [7:0] t[4];
        logic [7:0] tmp;
        logic [7:0] rcon;
        rcon = 8'h01;
        for (int i = 0; i < 16; i++) kb[i] = key[8*i +: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = kb[i-4+j];
            if (i % 16 == 0) begin
                tmp = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = tmp;
                for (int j = 0; j < 4; j++) t[j] = sbox_t[t[j]];
                t[0] ^= rcon;
                rcon = gmul(rcon, 8'h02);
            end
            for (int j = 0; j < 4; j++) kb[i+j] = kb[i-16+j] ^ t[j];
        end
        for (int r = 0; r < 11; r++)
            for (int j = 0; j < 16; j++) rks[slot][r][8*j +: 8] = kb[16*r + j];
    endtask

    // Reference inverse cipher on a 4x4 [row][col] byte matrix.
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input int slot);
        logic [7:0]   st[4][4];
        logic [7:0]   tmp[4][4];
        logic [127:0] k;
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) st[r][c] = ct[8*(r+4*c) +: 8] ^ rks[slot][10][8*(r+4*c) +: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            k = rks[slot][rnd];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) tmp[r][c] = inv_t[st[r][(c - r + 4) % 4]] ^ k[8*(r+4*c) +: 8];
            if (rnd == 0) begin
                st = tmp;
            end else begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        st[r][c] = gmul(tmp[r][c], 8'h0e) ^ gmul(tmp[(r+1)%4][c], 8'h0b)
                                 ^ gmul(tmp[(r+2)%4][c], 8'h0d) ^ gmul(tmp[(r+3)%4][c], 8'h09);
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[8*(r+4*c) +: 8] = st[r][c];
        return o;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard producer: every accepted block pushes its expected plaintext.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back('{stamp: cyc + 1, pt: pres_exp});
            cur_slot <= pres_slot;
        end
    end

    // Monitor: cycle k after the accept edge is busy for k=1..10, completes at k=11.
    always @(negedge clk) begin
        logic exp_out;
        logic exp_busy;
        exp_out  = exp_q.size() > 0 && cyc == exp_q[0].stamp + 10;
        exp_busy = exp_q.size() > 0 && cyc <= exp_q[0].stamp + 9;
        check("in_ready", 128'(in_ready), 128'(!exp_busy));
        check("rk_idx", 128'(rk_idx), exp_busy ? 128'(exp_q[0].stamp + 9 - cyc) : 128'd10);
        check("out_valid", 128'(out_valid), 128'(exp_out));
        if (exp_out) begin
            check("pt_out", pt_out, exp_q[0].pt);
            last_pt = exp_q[0].pt;
            void'(exp_q.pop_front());
        end else begin
            check("pt_hold", pt_out, last_pt);
        end
    end

    task automatic send(input logic [127:0] ct, input int slot, input logic [127:0] exp);
        bit done;
        done      = 0;
        in_valid  = 1'b1;
        ct_in     = ct;
        pres_slot = slot;
        pres_exp  = exp;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            done = in_ready;
        end
        if (!done) check("accept_timeout", 128'd0, 128'd1);
        @(negedge clk);
    endtask

    task automatic drain();
        bit empty;
        empty = 0;
        for (int i = 0; i < 40 && !empty; i++) begin
            @(negedge clk);
            #1 empty = exp_q.size() == 0;
        end
        check("drain", 128'(empty), 128'd1);
    endtask

    logic [127:0] c1_ct, c1_pt, b_ct, b_pt, key, ct;

    initial begin
        build_sbox();
        expand_key(bswap(128'h000102030405060708090a0b0c0d0e0f), 0);
        expand_key(bswap(128'h2b7e151628aed2a6abf7158809cf4f3c), 1);
        c1_ct = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        c1_pt = bswap(128'h00112233445566778899aabbccddeeff);
        b_ct  = bswap(128'h3925841d02dc09fbdc118597196a0b32);
        b_pt  = bswap(128'h3243f6a8885a308d313198a2e0370734);

        #1;
        check("reset_in_ready", 128'(in_ready), 128'd1);
        check("reset_rk_idx", 128'(rk_idx), 128'd10);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_pt_out", pt_out, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(c1_ct, 0, c1_pt);
        in_valid = 1'b0;
        drain();
        send(b_ct, 1, b_pt);
        in_valid = 1'b0;
        drain();

        // Busy-ignore and back-to-back: App. B is offered throughout the C.1 block.
        send(c1_ct, 0, c1_pt);
        send(b_ct, 1, b_pt);
        in_valid = 1'b0;
        drain();

        // Reset in cycle T+5 discards the block.
        send(c1_ct, 0, c1_pt);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        last_pt = '0;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        check("midrst_rk_idx", 128'(rk_idx), 128'd10);
        check("midrst_pt_out", pt_out, 128'd0);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(c1_ct, 0, c1_pt);
        in_valid = 1'b0;
        drain();

        for (int n = 0; n < 10; n++) begin
            int slot;
            slot = 2 + (n % 14);
            key  = {$urandom, $urandom, $urandom, $urandom};
            ct   = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key, slot);
            send(ct, slot, model_decrypt(ct, slot));
            if ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        in_valid = 1'b0;
        drain();

        // Idle hold: the monitor checks pt_out, out_valid and in_ready each cycle.
        repeat (50) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
